fpga_ip_test_sequencer: RTL



---
 rtl/fpga_ip_test_seq_pkg.sv | 19 +
 rtl/fpga_ip_test_sequencer_if.sv | 33 +++
 rtl/fpga_ip_test_seq_timer.sv | 28 ++
 rtl/fpga_ip_test_sequencer.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/fpga_ip_test_seq_pkg.sv
// Shared types and default configuration for the FPGA IP test sequencer.
package fpga_ip_test_seq_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StScan,
    StLaunch,
    StWait,
    StRecord,
    StDone
  } seq_state_e;

  localparam int unsigned DefNumTests     = 9;
  localparam int unsigned DefCntWidth     = 8;
  localparam int unsigned DefIdxWidth     = 5;
  localparam int unsigned DefTimeoutCycles = 65535;
  localparam int unsigned DefStopOnFail   = 0;

endpackage

// File: rtl/fpga_ip_test_sequencer_if.sv
// Control/result bundle between the register block (master) and the test sequencer (slave).
interface fpga_ip_test_sequencer_if #(
  parameter int unsigned NUM_TESTS = 9,
  parameter int unsigned CNT_WIDTH = 8,
  parameter int unsigned IDX_WIDTH = 5
);
  logic                 start_i;
  logic                 abort_i;
  logic [NUM_TESTS-1:0] test_enable_i;
  logic [NUM_TESTS-1:0] test_start_o;
  logic [NUM_TESTS-1:0] test_done_i;
  logic [NUM_TESTS-1:0] test_pass_i;
  logic                 busy_o;
  logic                 done_o;
  logic                 aborted_o;
  logic [IDX_WIDTH-1:0] cur_test_o;
  logic [CNT_WIDTH-1:0] pass_count_o;
  logic [CNT_WIDTH-1:0] fail_count_o;
  logic [NUM_TESTS-1:0] fail_mask_o;
  logic [NUM_TESTS-1:0] timeout_mask_o;

  modport master (
    output start_i, abort_i, test_enable_i, test_done_i, test_pass_i,
    input  test_start_o, busy_o, done_o, aborted_o, cur_test_o,
    input  pass_count_o, fail_count_o, fail_mask_o, timeout_mask_o
  );

  modport slave (
    input  start_i, abort_i, test_enable_i, test_done_i, test_pass_i,
    output test_start_o, busy_o, done_o, aborted_o, cur_test_o,
    output pass_count_o, fail_count_o, fail_mask_o, timeout_mask_o
  );
endinterface

// File: rtl/fpga_ip_test_seq_timer.sv
// Per-test watchdog for the test sequencer; only built when FPGA_IP_TEST_SEQ_TIMEOUT_EN is defined.
`ifdef FPGA_IP_TEST_SEQ_TIMEOUT_EN
module fpga_ip_test_seq_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic expired
);
  localparam int unsigned Limit = TIMEOUT_CYCLES - 1;

  logic [31:0] cnt_q;

  // Holds at the limit so expired stays asserted until cleared.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (!expired) begin
      cnt_q <= cnt_q + 32'd1;
    end
  end

  assign expired = (cnt_q == Limit);
endmodule
`endif

// File: rtl/fpga_ip_test_sequencer.sv
// Launches enabled test channels in ascending order and tallies pass/fail results.
// Per-test watchdog is compiled in with FPGA_IP_TEST_SEQ_TIMEOUT_EN.
module fpga_ip_test_sequencer
  import fpga_ip_test_seq_pkg::*;
#(
  parameter int unsigned NUM_TESTS      = DefNumTests,
  parameter int unsigned CNT_WIDTH      = DefCntWidth,
  parameter int unsigned IDX_WIDTH      = DefIdxWidth,
  parameter int unsigned TIMEOUT_CYCLES = DefTimeoutCycles,
  parameter int unsigned STOP_ON_FAIL   = DefStopOnFail
) (
  input logic                     WBs_CLK_i,
  input logic                     WBs_RST_i,
  fpga_ip_test_sequencer_if.slave bus
);
  localparam logic [IDX_WIDTH-1:0] LastIdx = IDX_WIDTH'(NUM_TESTS - 1);

  seq_state_e           state_q, state_d;
  logic [IDX_WIDTH-1:0] idx_q, idx_d;
  logic [NUM_TESTS-1:0] en_q, en_d;
  logic [NUM_TESTS-1:0] start_q, start_d;
  logic [NUM_TESTS-1:0] fail_mask_q, fail_mask_d;
  logic [NUM_TESTS-1:0] to_mask_q, to_mask_d;
  logic [CNT_WIDTH-1:0] pass_cnt_q, pass_cnt_d;
  logic [CNT_WIDTH-1:0] fail_cnt_q, fail_cnt_d;
  logic                 res_pass_q, res_pass_d;
  logic                 res_to_q, res_to_d;
  logic                 aborted_q, aborted_d;

  logic [NUM_TESTS-1:0] sel;
  logic                 busy;
  logic                 cur_done;
  logic                 timeout;

  // One-hot select avoids indexing the test vectors with an over-wide index.
  assign sel      = NUM_TESTS'(1) << idx_q;
  assign cur_done = |(bus.test_done_i & sel);
  assign busy     = (state_q == StScan) || (state_q == StLaunch) ||
                    (state_q == StWait) || (state_q == StRecord);

`ifdef FPGA_IP_TEST_SEQ_TIMEOUT_EN
  fpga_ip_test_seq_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk    (WBs_CLK_i),
    .rst    (WBs_RST_i),
    .clear  (state_q != StWait),
    .expired(timeout)
  );
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    en_d        = en_q;
    start_d     = '0;
    fail_mask_d = fail_mask_q;
    to_mask_d   = to_mask_q;
    pass_cnt_d  = pass_cnt_q;
    fail_cnt_d  = fail_cnt_q;
    res_pass_d  = res_pass_q;
    res_to_d    = res_to_q;
    aborted_d   = aborted_q;

    if (busy && bus.abort_i) begin
      // In-flight test is dropped, including a done seen this same cycle.
      state_d   = StDone;
      aborted_d = 1'b1;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          if (bus.start_i) begin
            en_d        = bus.test_enable_i;
            pass_cnt_d  = '0;
            fail_cnt_d  = '0;
            fail_mask_d = '0;
            to_mask_d   = '0;
            aborted_d   = 1'b0;
            idx_d       = '0;
            state_d     = StScan;
          end
        end
        StScan: begin
          if (|(en_q & sel)) begin
            start_d = sel;
            state_d = StLaunch;
          end else if (idx_q == LastIdx) begin
            state_d = StDone;
          end else begin
            idx_d = idx_q + IDX_WIDTH'(1);
          end
        end
        StLaunch: state_d = StWait;
        StWait: begin
          if (cur_done) begin
            res_pass_d = |(bus.test_pass_i & sel);
            res_to_d   = 1'b0;
            state_d    = StRecord;
          end else if (timeout) begin
            res_pass_d = 1'b0;
            res_to_d   = 1'b1;
            state_d    = StRecord;
          end
        end
        StRecord: begin
          if (res_pass_q) begin
            if (!(&pass_cnt_q)) pass_cnt_d = pass_cnt_q + CNT_WIDTH'(1);
          end else begin
            if (!(&fail_cnt_q)) fail_cnt_d = fail_cnt_q + CNT_WIDTH'(1);
            fail_mask_d = fail_mask_q | sel;
            if (res_to_q) to_mask_d = to_mask_q | sel;
          end
          if ((idx_q == LastIdx) || ((STOP_ON_FAIL != 0) && !res_pass_q)) begin
            state_d = StDone;
          end else begin
            idx_d   = idx_q + IDX_WIDTH'(1);
            state_d = StScan;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge WBs_CLK_i or posedge WBs_RST_i) begin
    if (WBs_RST_i) begin
      state_q     <= StIdle;
      idx_q       <= '0;
      en_q        <= '0;
      start_q     <= '0;
      fail_mask_q <= '0;
      to_mask_q   <= '0;
      pass_cnt_q  <= '0;
      fail_cnt_q  <= '0;
      res_pass_q  <= 1'b0;
      res_to_q    <= 1'b0;
      aborted_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      en_q        <= en_d;
      start_q     <= start_d;
      fail_mask_q <= fail_mask_d;
      to_mask_q   <= to_mask_d;
      pass_cnt_q  <= pass_cnt_d;
      fail_cnt_q  <= fail_cnt_d;
      res_pass_q  <= res_pass_d;
      res_to_q    <= res_to_d;
      aborted_q   <= aborted_d;
    end
  end

  assign bus.test_start_o   = start_q;
  assign bus.busy_o         = busy;
  assign bus.done_o         = (state_q == StDone);
  assign bus.aborted_o      = aborted_q;
  assign bus.cur_test_o     = idx_q;
  assign bus.pass_count_o   = pass_cnt_q;
  assign bus.fail_count_o   = fail_cnt_q;
  assign bus.fail_mask_o    = fail_mask_q;
`ifdef FPGA_IP_TEST_SEQ_TIMEOUT_EN
  assign bus.timeout_mask_o = to_mask_q;
`else
  assign bus.timeout_mask_o = '0;
`endif
endmodule
